// File: rtl/alu_src_b_stage_if.sv
// Operand-B select stage bundle: decode-side request plus ALU-side result channel.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready valid-ready handshakes carried through the bundle.
interface alu_src_b_stage_if #(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 16,
    parameter int SHAMT_W = 5
) ();
    // request channel from decode / regfile read
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         sel;
    logic               ext_sign;
    logic [DATA_W-1:0]  reg_data;
    logic [IMM_W-1:0]   imm;
    logic [SHAMT_W-1:0] shamt;

    // result channel to the ALU
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic               out_shift;

    // decode/ALU environment view
    modport master (
        output in_valid, sel, ext_sign, reg_data, imm, shamt, out_ready,
        input  in_ready, out_valid, out_data, out_shift
    );

    // stage view
    modport slave (
        input  in_valid, sel, ext_sign, reg_data, imm, shamt, out_ready,
        output in_ready, out_valid, out_data, out_shift
    );
endinterface

// File: rtl/alu_src_b_stage.sv
// ALU operand-B select/extend stage registered behind a 2-entry skid buffer.
// Latency: 1 cycle from accepted request to out_valid when empty; strict FIFO order.
// Backpressure: in_ready depends only on registered occupancy, never on out_ready.
module alu_src_b_stage #(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 16,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    alu_src_b_stage_if.slave bus
);

    generate
        if (DATA_W < IMM_W) begin : g_chk_imm
            $error("alu_src_b_stage: DATA_W must be >= IMM_W");
        end
        if (DATA_W < SHAMT_W) begin : g_chk_shamt
            $error("alu_src_b_stage: DATA_W must be >= SHAMT_W");
        end
    endgenerate

    typedef struct packed {
        logic              shift;
        logic [DATA_W-1:0] data;
    } operand_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t   state;
    state_t   state_nxt;
    operand_t new_op;
    operand_t main_q;
    operand_t skid_q;
    logic     in_xfer;
    logic     out_xfer;

    // LUI placement is done wide so the shift never loses bits before truncation
    logic [DATA_W+IMM_W-1:0] lui_wide;
    assign lui_wide = {{DATA_W{1'b0}}, bus.imm} << IMM_W;

    assign in_xfer  = bus.in_valid  & bus.in_ready;
    assign out_xfer = bus.out_valid & bus.out_ready;

    // Select and width-adjust the candidate operand from the current inputs
    always_comb begin
        new_op = '0;
        case (bus.sel)
            2'b00: new_op.data = bus.reg_data;
            2'b01: begin
                new_op.data = DATA_W'(bus.imm);
                if (bus.ext_sign && bus.imm[IMM_W-1])
                    new_op.data = new_op.data | ~DATA_W'({IMM_W{1'b1}});
            end
            2'b10: begin
                new_op.data  = DATA_W'(bus.shamt);
                new_op.shift = 1'b1;
            end
            default: new_op.data = lui_wide[DATA_W-1:0];
        endcase
    end

    // Occupancy state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    // Occupancy next-state from the two handshakes
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (in_xfer) state_nxt = ONE;
            ONE: begin
                if (in_xfer && !out_xfer)      state_nxt = FULL;
                else if (!in_xfer && out_xfer) state_nxt = EMPTY;
            end
            FULL:    if (out_xfer) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    // Main/skid payload registers; main always holds the oldest operand
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            case (state)
                EMPTY: if (in_xfer) main_q <= new_op;
                ONE: begin
                    if (in_xfer && out_xfer) main_q <= new_op;
                    else if (in_xfer)        skid_q <= new_op;
                end
                FULL:    if (out_xfer) main_q <= skid_q;
                default: ;
            endcase
        end
    end

    // Handshake and payload outputs, all from registered state
    always_comb begin
        bus.in_ready  = !rst && (state != FULL);
        bus.out_valid = (state != EMPTY);
        bus.out_data  = main_q.data;
        bus.out_shift = main_q.shift;
    end

endmodule

// File: tb/tb_alu_src_b_stage.sv
// Self-checking bench for alu_src_b_stage: directed scenarios plus randomized traffic.
// Latency: checks 1-cycle fill latency and FIFO ordering against a queue model.
// Backpressure: random out_ready stalls, occupancy-based in_ready expectation.
module tb_alu_src_b_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    alu_src_b_stage_if #(.DATA_W(32)) i32 ();
    alu_src_b_stage_if #(.DATA_W(64)) i64 ();

    alu_src_b_stage #(.DATA_W(32), .IMM_W(16), .SHAMT_W(5)) u_dut32 (
        .clk (clk),
        .rst (rst),
        .bus (i32)
    );

    alu_src_b_stage #(.DATA_W(64), .IMM_W(16), .SHAMT_W(5)) u_dut64 (
        .clk (clk),
        .rst (rst),
        .bus (i64)
    );

    // advance one clock, land just after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive32(input bit v, input logic [1:0] s, input bit es,
                           input logic [31:0] rd, input logic [15:0] im,
                           input logic [4:0] sh);
        i32.in_valid = v;
        i32.sel      = s;
        i32.ext_sign = es;
        i32.reg_data = rd;
        i32.imm      = im;
        i32.shamt    = sh;
    endtask

    // reference: operand value from the select rules using plain arithmetic
    function automatic logic [32:0] ref_op32(input logic [1:0] s, input bit es,
                                             input logic [31:0] rd,
                                             input logic [15:0] im,
                                             input logic [4:0] sh);
        longint v;
        case (s)
            2'd0: return {1'b0, rd};
            2'd1: begin
                v = longint'(im);
                if (es && im >= 16'd32768) v = v + 64'd4294901760;  // 2^32 - 2^16
                return {1'b0, v[31:0]};
            end
            2'd2: begin
                v = longint'(sh);
                return {1'b1, v[31:0]};
            end
            default: begin
                v = longint'(im) * 65536;
                return {1'b0, v[31:0]};
            end
        endcase
    endfunction

    task automatic test_reset();
        step();
        step();
        n_checks++;
        if (i32.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", i32.out_valid); end
        n_checks++;
        if (i32.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", i32.out_data); end
        n_checks++;
        if (i32.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready_held: got %b want 0", i32.in_ready); end
        rst = 1'b0;
        #1;
        n_checks++;
        if (i32.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_release: got %b want 1", i32.in_ready); end
        step();
    endtask

    task automatic test_extension();
        i32.out_ready = 1'b1;
        drive32(1, 2'b01, 1, 32'h0, 16'h8001, 5'h0);
        step();
        n_checks++;
        if (i32.out_valid !== 1'b1) begin n_fail++; $display("FAIL ext_latency: out_valid got %b want 1", i32.out_valid); end
        n_checks++;
        if (i32.out_data !== 32'hFFFF8001) begin n_fail++; $display("FAIL ext_sign1: got %h want ffff8001", i32.out_data); end
        drive32(1, 2'b01, 0, 32'h0, 16'h8001, 5'h0);
        step();
        n_checks++;
        if (i32.out_data !== 32'h00008001) begin n_fail++; $display("FAIL ext_sign0: got %h want 00008001", i32.out_data); end
        drive32(1, 2'b01, 1, 32'h0, 16'h7FFF, 5'h0);
        step();
        n_checks++;
        if (i32.out_data !== 32'h00007FFF) begin n_fail++; $display("FAIL ext_sign1_pos: got %h want 00007fff", i32.out_data); end
        drive32(0, 2'b00, 0, 32'h0, 16'h0, 5'h0);
        step();
        n_checks++;
        if (i32.out_valid !== 1'b0) begin n_fail++; $display("FAIL ext_drain: out_valid got %b want 0", i32.out_valid); end
    endtask

    task automatic test_shamt_lui();
        i32.out_ready = 1'b1;
        drive32(1, 2'b10, 0, 32'hDEADBEEF, 16'hFFFF, 5'h1F);
        step();
        n_checks++;
        if (i32.out_data !== 32'h0000001F) begin n_fail++; $display("FAIL shamt_data: got %h want 0000001f", i32.out_data); end
        n_checks++;
        if (i32.out_shift !== 1'b1) begin n_fail++; $display("FAIL shamt_flag: got %b want 1", i32.out_shift); end
        drive32(1, 2'b11, 1, 32'hDEADBEEF, 16'h1234, 5'h1F);
        step();
        n_checks++;
        if (i32.out_data !== 32'h12340000) begin n_fail++; $display("FAIL lui_data: got %h want 12340000", i32.out_data); end
        n_checks++;
        if (i32.out_shift !== 1'b0) begin n_fail++; $display("FAIL lui_flag: got %b want 0", i32.out_shift); end
        drive32(1, 2'b00, 1, 32'hCAFEF00D, 16'h1234, 5'h1F);
        step();
        n_checks++;
        if (i32.out_data !== 32'hCAFEF00D) begin n_fail++; $display("FAIL reg_data: got %h want cafef00d", i32.out_data); end
        drive32(0, 2'b00, 0, 32'h0, 16'h0, 5'h0);
        step();
    endtask

    task automatic test_back_pressure();
        i32.out_ready = 1'b0;
        drive32(1, 2'b00, 0, 32'd1, 16'h0, 5'h0);
        step();
        n_checks++;
        if (i32.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_a: got %b want 1", i32.in_ready); end
        drive32(1, 2'b00, 0, 32'd2, 16'h0, 5'h0);
        step();
        n_checks++;
        if (i32.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_full: got %b want 0", i32.in_ready); end
        drive32(1, 2'b00, 0, 32'd3, 16'h0, 5'h0);  // must be refused while full
        step();
        n_checks++;
        if (i32.out_data !== 32'd1) begin n_fail++; $display("FAIL bp_hold: got %h want 1", i32.out_data); end
        drive32(0, 2'b00, 0, 32'd0, 16'h0, 5'h0);
        i32.out_ready = 1'b1;
        step();
        n_checks++;
        if (i32.out_data !== 32'd2) begin n_fail++; $display("FAIL bp_second: got %h want 2", i32.out_data); end
        n_checks++;
        if (i32.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_pop: got %b want 1", i32.in_ready); end
        step();
        n_checks++;
        if (i32.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: out_valid got %b want 0", i32.out_valid); end
    endtask

    task automatic test_streaming();
        i32.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive32(1, 2'b00, 0, 32'(i), 16'h0, 5'h0);
            step();
            n_checks++;
            if (i32.out_valid !== 1'b1 || i32.out_data !== 32'(i)) begin
                n_fail++;
                $display("FAIL stream_%0d: valid %b data %h want valid 1 data %h", i, i32.out_valid, i32.out_data, i);
            end
            n_checks++;
            if (i32.in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready_%0d: got %b want 1", i, i32.in_ready); end
        end
        drive32(0, 2'b00, 0, 32'h0, 16'h0, 5'h0);
        step();
        n_checks++;
        if (i32.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain: out_valid got %b want 0", i32.out_valid); end
    endtask

    task automatic test_param64();
        i64.out_ready = 1'b1;
        i64.in_valid  = 1'b1;
        i64.sel       = 2'b01;
        i64.ext_sign  = 1'b1;
        i64.imm       = 16'hFFFF;
        step();
        n_checks++;
        if (i64.out_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_fail++; $display("FAIL p64_sext: got %h want all ones", i64.out_data); end
        i64.sel = 2'b11;
        step();
        n_checks++;
        if (i64.out_data !== 64'h0000_0000_FFFF_0000) begin n_fail++; $display("FAIL p64_lui: got %h want 00000000ffff0000", i64.out_data); end
        i64.sel   = 2'b10;
        i64.shamt = 5'h15;
        step();
        n_checks++;
        if (i64.out_data !== 64'h15 || i64.out_shift !== 1'b1) begin
            n_fail++;
            $display("FAIL p64_shamt: got %h/%b want 15/1", i64.out_data, i64.out_shift);
        end
        i64.in_valid = 1'b0;
        step();
    endtask

    task automatic test_random();
        logic [32:0] model_q[$];
        logic [32:0] exp_op;
        bit          iv, orr, in_x, out_x;
        logic [1:0]  s;
        bit          es;
        logic [31:0] rd;
        logic [15:0] im;
        logic [4:0]  sh;
        model_q.delete();
        for (int c = 0; c < 2000; c++) begin
            n_checks++;
            if (i32.out_valid !== (model_q.size() != 0)) begin
                n_fail++;
                $display("FAIL rnd_valid c%0d: got %b want %b", c, i32.out_valid, model_q.size() != 0);
            end
            n_checks++;
            if (i32.in_ready !== (model_q.size() < 2)) begin
                n_fail++;
                $display("FAIL rnd_ready c%0d: got %b want %b", c, i32.in_ready, model_q.size() < 2);
            end
            if (model_q.size() != 0) begin
                n_checks++;
                if ({i32.out_shift, i32.out_data} !== model_q[0]) begin
                    n_fail++;
                    $display("FAIL rnd_data c%0d: got %b/%h want %b/%h", c, i32.out_shift, i32.out_data, model_q[0][32], model_q[0][31:0]);
                end
            end
            iv  = ($urandom_range(0, 99) < 60);
            orr = ($urandom_range(0, 99) < 55);
            s   = 2'($urandom_range(0, 3));
            es  = 1'($urandom_range(0, 1));
            rd  = $urandom;
            im  = 16'($urandom);
            sh  = 5'($urandom);
            drive32(iv, s, es, rd, im, sh);
            i32.out_ready = orr;
            exp_op = ref_op32(s, es, rd, im, sh);
            in_x   = iv && (model_q.size() < 2);
            out_x  = orr && (model_q.size() != 0);
            step();
            if (out_x) void'(model_q.pop_front());
            if (in_x)  model_q.push_back(exp_op);
        end
        drive32(0, 2'b00, 0, 32'h0, 16'h0, 5'h0);
        i32.out_ready = 1'b1;
        step();
        step();
        n_checks++;
        if (i32.out_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_drain: out_valid got %b want 0", i32.out_valid); end
    endtask

    task automatic test_reset_mid_full();
        i32.out_ready = 1'b0;
        drive32(1, 2'b01, 1, 32'h0, 16'hABCD, 5'h0);
        step();
        drive32(1, 2'b10, 0, 32'h0, 16'h0, 5'h07);
        step();
        drive32(0, 2'b00, 0, 32'h0, 16'h0, 5'h0);
        n_checks++;
        if (i32.in_ready !== 1'b0) begin n_fail++; $display("FAIL rstfull_setup: in_ready got %b want 0", i32.in_ready); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (i32.out_valid !== 1'b0 || i32.out_data !== 32'h0 || i32.out_shift !== 1'b0) begin
            n_fail++;
            $display("FAIL rstfull_async: valid %b data %h shift %b want 0/0/0", i32.out_valid, i32.out_data, i32.out_shift);
        end
        n_checks++;
        if (i32.in_ready !== 1'b0) begin n_fail++; $display("FAIL rstfull_ready_held: got %b want 0", i32.in_ready); end
        step();
        rst = 1'b0;
        #1;
        n_checks++;
        if (i32.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstfull_ready_release: got %b want 1", i32.in_ready); end
        i32.out_ready = 1'b1;
        step();
        n_checks++;
        if (i32.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstfull_discard: out_valid got %b want 0", i32.out_valid); end
    endtask

    initial begin
        drive32(0, 2'b00, 0, 32'h0, 16'h0, 5'h0);
        i32.out_ready = 1'b0;
        i64.in_valid  = 1'b0;
        i64.sel       = 2'b00;
        i64.ext_sign  = 1'b0;
        i64.reg_data  = 64'h0;
        i64.imm       = 16'h0;
        i64.shamt     = 5'h0;
        i64.out_ready = 1'b0;
        test_reset();
        test_extension();
        test_shamt_lui();
        test_back_pressure();
        test_streaming();
        test_param64();
        test_random();
        test_reset_mid_full();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
